// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, keeps one I-cache request in flight and fills the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the fetched-instruction and wait-cycle counters.
module instr_fetch_unit #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            o_ic_req,
    output logic [XLEN-1:0] o_ic_addr,
    input  logic            i_ic_gnt,
    input  logic            i_ic_rvalid,
    input  logic [31:0]     i_ic_rdata,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_ifid_valid,
    output logic [31:0]     o_ifid_instr,
    output logic [XLEN-1:0] o_ifid_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     o_perf_fetched,
    output logic [31:0]     o_perf_wait_cyc,
`endif
    output logic [5:0]      o_ifid_op
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StDrain} state_e;

    state_e          r_state, w_state_d;
    logic            r_run;
    logic [XLEN-1:0] r_pc, w_pc_d;
    logic            r_ifid_valid, w_ifid_valid_d;
    logic [31:0]     r_ifid_instr, w_ifid_instr_d;
    logic [XLEN-1:0] r_ifid_pc, w_ifid_pc_d;
    logic [31:0]     r_skid_instr, w_skid_instr_d;
    logic [XLEN-1:0] r_skid_pc, w_skid_pc_d;
    logic            w_load;
    logic [XLEN-1:0] w_redirect_tgt;
    logic [XLEN-1:0] w_pc_inc;

    assign w_redirect_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign w_pc_inc       = r_pc + XLEN'(4);

    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        // Without a stall, decode consumes IF/ID every cycle, so it empties unless refilled.
        w_ifid_valid_d = i_stall ? r_ifid_valid : 1'b0;
        w_ifid_instr_d = r_ifid_instr;
        w_ifid_pc_d    = r_ifid_pc;
        w_skid_instr_d = r_skid_instr;
        w_skid_pc_d    = r_skid_pc;
        w_load         = 1'b0;

        unique case (r_state)
            StReq: begin
                if (i_redirect) begin
                    w_pc_d = w_redirect_tgt;
                    // A request granted alongside a redirect still returns data; drop it.
                    if (r_run && i_ic_gnt) w_state_d = StDrain;
                end else if (r_run && i_ic_gnt) begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (i_redirect) begin
                    w_pc_d    = w_redirect_tgt;
                    w_state_d = i_ic_rvalid ? StReq : StDrain;
                end else if (i_ic_rvalid) begin
                    w_pc_d = w_pc_inc;
                    if (i_stall) begin
                        w_skid_instr_d = i_ic_rdata;
                        w_skid_pc_d    = r_pc;
                        w_state_d      = StHold;
                    end else begin
                        w_load         = 1'b1;
                        w_ifid_instr_d = i_ic_rdata;
                        w_ifid_pc_d    = r_pc;
                        w_state_d      = StReq;
                    end
                end
            end
            StHold: begin
                if (i_redirect) begin
                    w_pc_d    = w_redirect_tgt;
                    w_state_d = StReq;
                end else if (!i_stall) begin
                    w_load         = 1'b1;
                    w_ifid_instr_d = r_skid_instr;
                    w_ifid_pc_d    = r_skid_pc;
                    w_state_d      = StReq;
                end
            end
            StDrain: begin
                if (i_redirect) w_pc_d = w_redirect_tgt;
                if (i_ic_rvalid) w_state_d = StReq;
            end
            default: w_state_d = StReq;
        endcase

        if (w_load) w_ifid_valid_d = 1'b1;
        if (i_redirect || i_flush) w_ifid_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StReq;
            r_run        <= 1'b0;
            r_pc         <= RESET_PC[XLEN-1:0];
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            r_state      <= w_state_d;
            r_run        <= 1'b1;
            r_pc         <= w_pc_d;
            r_ifid_valid <= w_ifid_valid_d;
            r_ifid_instr <= w_ifid_instr_d;
            r_ifid_pc    <= w_ifid_pc_d;
            r_skid_instr <= w_skid_instr_d;
            r_skid_pc    <= w_skid_pc_d;
        end
    end

    assign o_ic_req     = r_run && (r_state == StReq);
    assign o_ic_addr    = {r_pc[XLEN-1:2], 2'b00};
    assign o_ifid_valid = r_ifid_valid;
    assign o_ifid_instr = r_ifid_instr;
    assign o_ifid_pc    = r_ifid_pc;
    assign o_ifid_op    = r_ifid_instr[5:0];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_wait_cyc;
    logic        w_fetched;

    assign w_fetched = w_load && !i_redirect && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched  <= '0;
            r_perf_wait_cyc <= '0;
        end else begin
            if (w_fetched && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if ((r_state == StWait) && (r_perf_wait_cyc != 32'hFFFF_FFFF)) begin
                r_perf_wait_cyc <= r_perf_wait_cyc + 32'd1;
            end
        end
    end

    assign o_perf_fetched  = r_perf_fetched;
    assign o_perf_wait_cyc = r_perf_wait_cyc;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hit streaming, stall/skid, redirects, flush, PC wrap, async reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_gnt;
    logic        ic_rvalid;
    logic [31:0] ic_rdata;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [5:0]  ifid_op;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_wait_cyc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .o_ic_req        (ic_req),
        .o_ic_addr       (ic_addr),
        .i_ic_gnt        (ic_gnt),
        .i_ic_rvalid     (ic_rvalid),
        .i_ic_rdata      (ic_rdata),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_redirect      (redirect),
        .i_redirect_pc   (redirect_pc),
        .o_ifid_valid    (ifid_valid),
        .o_ifid_instr    (ifid_instr),
        .o_ifid_pc       (ifid_pc),
`ifdef FETCH_PERF_CNT_EN
        .o_perf_fetched  (perf_fetched),
        .o_perf_wait_cyc (perf_wait_cyc),
`endif
        .o_ifid_op       (ifid_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 1-cycle-hit fetch starting in REQ at addr; ends in REQ at addr+4.
    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data,
                             input logic [5:0] op);
        check_eq("req_in_req", {31'd0, ic_req}, 32'd1);
        check_eq("addr_in_req", ic_addr, addr);
        ic_gnt = 1'b1;
        tick();
        ic_gnt = 1'b0;
        check_eq("req_in_wait", {31'd0, ic_req}, 32'd0);
        ic_rvalid = 1'b1;
        ic_rdata  = data;
        tick();
        ic_rvalid = 1'b0;
        check_eq("hit_valid", {31'd0, ifid_valid}, 32'd1);
        check_eq("hit_instr", ifid_instr, data);
        check_eq("hit_pc", ifid_pc, addr);
        check_eq("hit_op", {26'd0, ifid_op}, {26'd0, op});
        check_eq("next_addr", ic_addr, addr + 32'd4);
    endtask

    initial begin
        rst_n       = 1'b0;
        ic_gnt      = 1'b0;
        ic_rvalid   = 1'b0;
        ic_rdata    = 32'h0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #1;
        check_eq("rst_req", {31'd0, ic_req}, 32'd0);
        check_eq("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("rst_instr", ifid_instr, 32'd0);
        check_eq("rst_pc", ifid_pc, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("first_req", {31'd0, ic_req}, 32'd1);
        check_eq("first_addr", ic_addr, 32'h0000_0000);

        // Streaming hits
        fetch_hit(32'h0000_0000, 32'hA5A5_0023, 6'h23);
        fetch_hit(32'h0000_0004, 32'h1234_56BF, 6'h3F);
        fetch_hit(32'h0000_0008, 32'h0F0F_0F01, 6'h01);

        // Stall: response goes to skid, IF/ID frozen for 3 HOLD cycles
        stall  = 1'b1;
        ic_gnt = 1'b1;
        tick();
        ic_gnt    = 1'b0;
        ic_rvalid = 1'b1;
        ic_rdata  = 32'hDEAD_BE2A;
        tick();
        ic_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_req", {31'd0, ic_req}, 32'd0);
            check_eq("stall_valid", {31'd0, ifid_valid}, 32'd1);
            check_eq("stall_instr", ifid_instr, 32'h0F0F_0F01);
            check_eq("stall_pc", ifid_pc, 32'h0000_0008);
            if (i == 2) stall = 1'b0;
            tick();
        end
        check_eq("unstall_valid", {31'd0, ifid_valid}, 32'd1);
        check_eq("unstall_instr", ifid_instr, 32'hDEAD_BE2A);
        check_eq("unstall_pc", ifid_pc, 32'h0000_000C);
        check_eq("unstall_op", {26'd0, ifid_op}, 32'h0000_002A);
        check_eq("unstall_addr", ic_addr, 32'h0000_0010);
        check_eq("unstall_req", {31'd0, ic_req}, 32'd1);

        // Redirect in WAIT, late response discarded in DRAIN
        ic_gnt = 1'b1;
        tick();
        ic_gnt      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check_eq("drain_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("drain_req", {31'd0, ic_req}, 32'd0);
        ic_rvalid = 1'b1;
        ic_rdata  = 32'hBAD0_BAD0;
        tick();
        ic_rvalid = 1'b0;
        check_eq("post_drain_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("post_drain_req", {31'd0, ic_req}, 32'd1);
        check_eq("post_drain_addr", ic_addr, 32'h0000_0100);

        // Redirect coincident with rvalid
        ic_gnt = 1'b1;
        tick();
        ic_gnt      = 1'b0;
        ic_rvalid   = 1'b1;
        ic_rdata    = 32'hCAFE_F00D;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        ic_rvalid = 1'b0;
        redirect  = 1'b0;
        check_eq("same_cyc_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("same_cyc_req", {31'd0, ic_req}, 32'd1);
        check_eq("same_cyc_addr", ic_addr, 32'h0000_0200);

        // Redirect in REQ to the top word, then wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        fetch_hit(32'hFFFF_FFFC, 32'h7777_7785, 6'h05);
        check_eq("wrap_addr", ic_addr, 32'h0000_0000);

        // Flush drops the loaded instruction but fetch continues
        ic_gnt = 1'b1;
        tick();
        ic_gnt    = 1'b0;
        ic_rvalid = 1'b1;
        ic_rdata  = 32'h5555_5555;
        flush     = 1'b1;
        tick();
        ic_rvalid = 1'b0;
        flush     = 1'b0;
        check_eq("flush_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("flush_addr", ic_addr, 32'h0000_0004);

        // Async reset in WAIT
        fetch_hit(32'h0000_0004, 32'h0000_1113, 6'h13);
        stall  = 1'b1;
        ic_gnt = 1'b1;
        tick();
        ic_gnt = 1'b0;
        check_eq("pre_rst_valid", {31'd0, ifid_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", {31'd0, ifid_valid}, 32'd0);
        check_eq("async_req", {31'd0, ic_req}, 32'd0);
        check_eq("async_instr", ifid_instr, 32'd0);
        stall = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        check_eq("restart_req", {31'd0, ic_req}, 32'd1);
        check_eq("restart_addr", ic_addr, 32'h0000_0000);
        fetch_hit(32'h0000_0000, 32'h0000_0017, 6'h17);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
